if_id_elastic_reg: RTL
======================

# if_id_elastic_reg

Parametrised, elastic successor to the fixed IF/ID pipeline register: a two-entry (main + skid) buffer carrying an instruction word and its PC from the fetch stage to the decode stage under a valid/ready handshake. It adds per-entry valid tracking, a synchronous flush for branch/jump redirects, a global BUSYWAIT freeze for memory stalls, and an optional stall-cycle counter. It sits between the instruction-memory/fetch logic and the decoder in the RV32IM pipeline.

## Interface
- INSTR_W, 32, instruction word width
- PC_W, 32, PC width
- RESET_PC, 32'hFFFF_FFFC (−4), PC value presented while empty/after reset or flush
- NOP_INSTR, 32'h0000_0013 (ADDI x0,x0,0), instruction presented while empty
- STALL_CNT_W, 16, stall counter width (used only with IF_ID_STALL_CNT_EN)

- CLK  in  1  clock; all state updates on the rising edge
- RESET  in  1  asynchronous, active-low reset
- IN_INSTRUCTION  in  INSTR_W  fetched instruction
- IN_PC  in  PC_W  PC of fetched instruction
- IN_VALID  in  1  fetch presents an instruction
- IN_READY  out  1  block can accept this cycle
- OUT_INSTRUCTION  out  INSTR_W  instruction to decode
- OUT_PC  out  PC_W  PC to decode
- OUT_VALID  out  1  OUT_* holds a live instruction
- OUT_READY  in  1  decode consumes this cycle
- FLUSH  in  1  discard all held instructions (synchronous)
- BUSYWAIT  in  1  global memory stall; freezes both handshakes
- STALL_COUNT  out  STALL_CNT_W  saturating stall-cycle count

## Operation
- accept = IN_VALID & IN_READY; consume = OUT_VALID & OUT_READY & !BUSYWAIT.
- IN_READY = !skid_valid & !BUSYWAIT (combinational from registered state).
- OUT_* driven directly from the main entry; OUT_VALID = main_valid. When main invalid, OUT_INSTRUCTION = NOP_INSTR, OUT_PC = RESET_PC.
- States (encoded by valid bits): EMPTY, ONE (main only), TWO (main + skid).
  - EMPTY: accept → ONE (main ← input).
  - ONE: accept & consume → ONE (main ← input); accept & !consume → TWO (skid ← input); consume only → EMPTY.
  - TWO: IN_READY low, no accept; consume → ONE (main ← skid); else hold.
- BUSYWAIT high: no accept, no consume, all state frozen; OUT_* hold their values.
- FLUSH high at a rising edge: both entries invalidated → EMPTY regardless of accept/consume/BUSYWAIT on that edge; the input on that edge is dropped. FLUSH has priority over BUSYWAIT.
- Ordering strictly FIFO; no instruction duplicated or lost except by FLUSH.
- RESET low (any time, including mid-transfer): state EMPTY, OUT_VALID 0, OUT_INSTRUCTION = NOP_INSTR, OUT_PC = RESET_PC, STALL_COUNT 0; IN_READY 0 while RESET low.

## Timing
- Latency: input accepted at edge N is on OUT_* after edge N (visible in cycle N+1) when arriving at EMPTY or ONE-with-consume.
- Throughput: one instruction per cycle with OUT_READY held high.
- IN_READY has no combinational path from OUT_READY; only from BUSYWAIT and registered skid_valid.
- A downstream stall of one cycle costs no fetch bubble (skid absorbs it); IN_READY drops the cycle after the skid fills.
- Reset release: first accept possible on the first rising edge with RESET high.

## Configuration
- IF_ID_STALL_CNT_EN defined: STALL_COUNT increments by 1 each rising edge where (OUT_VALID & !OUT_READY) | BUSYWAIT, saturating at all-ones; cleared by reset only (not by FLUSH).
- Undefined: counter logic not compiled; STALL_COUNT tied to 0.

## Test plan
- Reset: RESET low mid-stream with TWO occupied → OUT_VALID 0, OUT_PC 0xFFFFFFFC, OUT_INSTRUCTION 0x00000013, IN_READY 0 immediately (async).
- Streaming: PCs 0x0,0x4,0x8,0xC with IN_VALID/OUT_READY high → each appears one cycle later, one per cycle, in order, IN_READY constantly 1.
- Backpressure: OUT_READY low two cycles while feeding 0x10,0x14,0x18 → main=0x10, skid=0x14, IN_READY 0, 0x18 held upstream; OUT_READY high → 0x10,0x14,0x18 delivered back-to-back.
- Flush: TWO state plus IN_VALID with FLUSH → next cycle OUT_VALID 0, IN_READY 1; next accepted PC 0x40 is the only one emitted.
- BUSYWAIT: 3 cycles high with ONE state and IN_VALID/OUT_READY high → OUT_PC unchanged, IN_READY 0, no accept; with IF_ID_STALL_CNT_EN, STALL_COUNT = 3.
- Counter saturation (STALL_CNT_W=4, macro defined): 20 stall cycles → STALL_COUNT stays 15; FLUSH does not clear it.

Source files
------------

// File: rtl/if_id_elastic_reg_if.sv
// Fetch-to-decode handshake bundle for if_id_elastic_reg: the fetch-side
// (IN_*) and decode-side (OUT_*) valid/ready channels carrying instruction and PC.
interface if_id_elastic_reg_if #(
    parameter int INSTR_W = 32,
    parameter int PC_W    = 32
);
    logic [INSTR_W-1:0] IN_INSTRUCTION;
    logic [PC_W-1:0]    IN_PC;
    logic               IN_VALID;
    logic               IN_READY;

    logic [INSTR_W-1:0] OUT_INSTRUCTION;
    logic [PC_W-1:0]    OUT_PC;
    logic               OUT_VALID;
    logic               OUT_READY;

    // The register itself: consumes the fetch channel, produces the decode channel.
    modport slave (
        input  IN_INSTRUCTION, IN_PC, IN_VALID, OUT_READY,
        output IN_READY, OUT_INSTRUCTION, OUT_PC, OUT_VALID
    );

    // Surrounding logic (fetch + decode) seen as one agent.
    modport master (
        output IN_INSTRUCTION, IN_PC, IN_VALID, OUT_READY,
        input  IN_READY, OUT_INSTRUCTION, OUT_PC, OUT_VALID
    );
endinterface

// File: rtl/if_id_elastic_reg.sv
// Elastic IF/ID pipeline register: main + skid entry, FIFO order, flush, BUSYWAIT
// freeze. Optional saturating stall counter enabled by `define IF_ID_STALL_CNT_EN.
module if_id_elastic_reg #(
    parameter int                 INSTR_W     = 32,
    parameter int                 PC_W        = 32,
    parameter logic [PC_W-1:0]    RESET_PC    = 32'hFFFF_FFFC,
    parameter logic [INSTR_W-1:0] NOP_INSTR   = 32'h0000_0013,
    parameter int                 STALL_CNT_W = 16
) (
    input  logic                   CLK,
    input  logic                   RESET,
    if_id_elastic_reg_if.slave     bus,
    input  logic                   FLUSH,
    input  logic                   BUSYWAIT,
    output logic [STALL_CNT_W-1:0] STALL_COUNT
);

    // State encoding doubles as the valid bits: [0] = main valid, [1] = skid valid.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_TWO   = 2'b11
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [INSTR_W-1:0] r_main_instr;
    logic [PC_W-1:0]    r_main_pc;
    logic [INSTR_W-1:0] r_skid_instr;
    logic [PC_W-1:0]    r_skid_pc;

    logic w_main_valid;
    logic w_skid_valid;
    logic w_in_ready;
    logic w_accept;
    logic w_consume;
    logic w_load_main_in;
    logic w_load_main_skid;
    logic w_load_skid;

    assign w_main_valid = r_state[0];
    assign w_skid_valid = r_state[1];

    // IN_READY depends only on registered state, BUSYWAIT and reset, never on OUT_READY.
    assign w_in_ready = RESET & ~w_skid_valid & ~BUSYWAIT;
    assign w_accept   = bus.IN_VALID & w_in_ready;
    assign w_consume  = w_main_valid & bus.OUT_READY & ~BUSYWAIT;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state <= ST_EMPTY;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values regardless of block order.
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        // NOTE: defaults first so no path through the case leaves a signal unassigned (no latch).
        w_state_nxt      = r_state;
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        if (FLUSH) begin
            w_state_nxt = ST_EMPTY;
        end else begin
            unique case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        w_state_nxt    = ST_ONE;
                        w_load_main_in = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (w_accept && w_consume) begin
                        w_load_main_in = 1'b1;
                    end else if (w_accept) begin
                        w_state_nxt = ST_TWO;
                        w_load_skid = 1'b1;
                    end else if (w_consume) begin
                        w_state_nxt = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (w_consume) begin
                        w_state_nxt      = ST_ONE;
                        w_load_main_skid = 1'b1;
                    end
                end
                default: w_state_nxt = ST_EMPTY;
            endcase
        end
    end

    // NOTE: payload flops carry no reset; their contents are only observed when the
    // matching valid bit is set, and the valid bits are reset.
    always_ff @(posedge CLK) begin
        if (w_load_main_in) begin
            r_main_instr <= bus.IN_INSTRUCTION;
            r_main_pc    <= bus.IN_PC;
        end else if (w_load_main_skid) begin
            r_main_instr <= r_skid_instr;
            r_main_pc    <= r_skid_pc;
        end
        if (w_load_skid) begin
            r_skid_instr <= bus.IN_INSTRUCTION;
            r_skid_pc    <= bus.IN_PC;
        end
    end

    assign bus.IN_READY        = w_in_ready;
    assign bus.OUT_VALID       = w_main_valid;
    assign bus.OUT_INSTRUCTION = w_main_valid ? r_main_instr : NOP_INSTR;
    assign bus.OUT_PC          = w_main_valid ? r_main_pc    : RESET_PC;

`ifdef IF_ID_STALL_CNT_EN
    logic [STALL_CNT_W-1:0] r_stall_cnt;
    logic                   w_stall_evt;

    assign w_stall_evt = (w_main_valid & ~bus.OUT_READY) | BUSYWAIT;

    // Cleared by reset only; FLUSH deliberately leaves the statistic intact.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_stall_cnt <= '0;
        end else if (w_stall_evt && (r_stall_cnt != {STALL_CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + STALL_CNT_W'(1);
        end
    end

    assign STALL_COUNT = r_stall_cnt;
`else
    assign STALL_COUNT = '0;
`endif

endmodule
